// File: rtl/mem_port_arbiter.sv
// Arbitrates the single Avalon-style memory port between instruction fetch and load/store.
// Optional bus watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_rdata,
  output logic        fetch_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteen,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        addr_err,
  output logic        stall,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE, BUS_F, BUS_D, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [31:0] fetch_rdata_q, fetch_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        fetch_done_q, fetch_done_d;
  logic        data_done_q, data_done_d;
  logic        addr_err_q, addr_err_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        bus_timeout_q, bus_timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    writedata_d   = writedata_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    byteenable_d  = byteenable_q;
    read_d        = read_q;
    write_d       = write_q;
    fetch_done_d  = 1'b0;
    data_done_d   = 1'b0;
    addr_err_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    bus_timeout_d = bus_timeout_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d = 16'd0;
`endif
        if (data_req) begin
          address_d    = data_addr & 32'hFFFF_FFFC;
          byteenable_d = data_byteen;
          writedata_d  = data_wdata;
          write_d      = data_we;
          read_d       = ~data_we;
          state_d      = BUS_D;
        end else if (fetch_req) begin
          if (fetch_addr[1:0] == 2'b00) begin
            address_d    = fetch_addr & 32'hFFFF_FFFC;
            byteenable_d = 4'b1111;
            read_d       = 1'b1;
            write_d      = 1'b0;
            state_d      = BUS_F;
          end else begin
            // Misaligned fetch never reaches the bus; report it straight away.
            fetch_rdata_d = 32'h0;
            fetch_done_d  = 1'b1;
            addr_err_d    = 1'b1;
            state_d       = RESP;
          end
        end
      end
      BUS_F, BUS_D: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            if (state_q == BUS_D) data_rdata_d  = readdata;
            else                  fetch_rdata_d = readdata;
          end
          fetch_done_d = (state_q == BUS_F);
          data_done_d  = (state_q == BUS_D);
          state_d      = RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TO_LIM) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            if (read_q) begin
              if (state_q == BUS_D) data_rdata_d  = 32'h0;
              else                  fetch_rdata_d = 32'h0;
            end
            fetch_done_d  = (state_q == BUS_F);
            data_done_d   = (state_q == BUS_D);
            bus_timeout_d = 1'b1;
            state_d       = RESP;
          end
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      address_q     <= 32'h0;
      writedata_q   <= 32'h0;
      fetch_rdata_q <= 32'h0;
      data_rdata_q  <= 32'h0;
      byteenable_q  <= 4'b0000;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      fetch_done_q  <= 1'b0;
      data_done_q   <= 1'b0;
      addr_err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= 16'd0;
      bus_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      writedata_q   <= writedata_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      byteenable_q  <= byteenable_d;
      read_q        <= read_d;
      write_q       <= write_d;
      fetch_done_q  <= fetch_done_d;
      data_done_q   <= data_done_d;
      addr_err_q    <= addr_err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      bus_timeout_q <= bus_timeout_d;
`endif
    end
  end

  assign stall       = ((state_q == IDLE) && (fetch_req || data_req)) ||
                       (state_q == BUS_F) || (state_q == BUS_D);
  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;
  assign byteenable  = byteenable_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign fetch_done  = fetch_done_q;
  assign data_done   = data_done_q;
  assign addr_err    = addr_err_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_timeout = bus_timeout_q;
`else
  assign bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store with wait states, contention,
// misaligned fetch, mid-transaction reset and (with MEM_TIMEOUT_EN) the watchdog.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        fetch_done;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_byteen;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        addr_err;
  logic        stall;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        bus_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata),
    .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_byteen(data_byteen), .data_rdata(data_rdata),
    .data_done(data_done), .addr_err(addr_err), .stall(stall),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
    .bus_timeout(bus_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes before checking.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0; data_addr = 0;
    data_wdata = 0; data_byteen = 0; readdata = 0; waitrequest = 0;

    // Reset state
    #12;
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_addr", address, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_frd", fetch_rdata, 0);
    chk("rst_drd", data_rdata, 0);
    chk("rst_done", {fetch_done, data_done, addr_err, bus_timeout}, 0);
    chk("rst_stall", stall, 0);
    cyc();
    rst = 1'b1;
    cyc();

    // Aligned fetch, no wait states
    fetch_req = 1; fetch_addr = 32'hBFC0_0000; readdata = 32'h2402_0005; settle();
    chk("f_c0_stall", stall, 1);
    chk("f_c0_read", read, 0);
    cyc(); settle();
    chk("f_c1_read", read, 1);
    chk("f_c1_addr", address, 32'hBFC0_0000);
    chk("f_c1_be", byteenable, 4'hF);
    chk("f_c1_stall", stall, 1);
    chk("f_c1_done", fetch_done, 0);
    cyc(); settle();
    chk("f_c2_done", fetch_done, 1);
    chk("f_c2_rdata", fetch_rdata, 32'h2402_0005);
    chk("f_c2_stall", stall, 0);
    chk("f_c2_read", read, 0);
    chk("f_c2_aerr", addr_err, 0);
    fetch_req = 0;
    cyc(); settle();
    chk("f_c3_done", fetch_done, 0);

    // Store with three wait states
    data_req = 1; data_we = 1; data_addr = 32'h0000_1003; data_wdata = 32'hDEAD_BEEF;
    data_byteen = 4'b1000; waitrequest = 1; readdata = 32'h1111_1111;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) waitrequest = 0;
      settle();
      chk("s_write", write, 1);
      chk("s_read", read, 0);
      chk("s_addr", address, 32'h0000_1000);
      chk("s_wdata", writedata, 32'hDEAD_BEEF);
      chk("s_be", byteenable, 4'b1000);
      chk("s_stall", stall, 1);
      chk("s_done", data_done, 0);
      cyc();
    end
    settle();
    chk("s_done_p", data_done, 1);
    chk("s_write_off", write, 0);
    chk("s_drd", data_rdata, 0);
    chk("s_fdone", fetch_done, 0);
    data_req = 0; data_we = 0;
    cyc(); settle();
    chk("s_done_off", data_done, 0);

    // Simultaneous fetch and load: data first
    fetch_req = 1; fetch_addr = 32'h0000_0100;
    data_req = 1; data_addr = 32'h0000_2004; data_byteen = 4'hF; readdata = 32'hCAFE_F00D;
    cyc(); settle();
    chk("c_c1_read", read, 1);
    chk("c_c1_addr", address, 32'h0000_2004);
    cyc(); settle();
    chk("c_c2_ddone", data_done, 1);
    chk("c_c2_fdone", fetch_done, 0);
    chk("c_c2_drd", data_rdata, 32'hCAFE_F00D);
    chk("c_c2_read", read, 0);
    cyc();
    data_req = 0; readdata = 32'h1234_5678; settle();
    chk("c_c3_stall", stall, 1);
    chk("c_c3_dones", {fetch_done, data_done}, 0);
    chk("c_c3_read", read, 0);
    cyc(); settle();
    chk("c_c4_read", read, 1);
    chk("c_c4_addr", address, 32'h0000_0100);
    chk("c_c4_dones", {fetch_done, data_done}, 0);
    cyc(); settle();
    chk("c_c5_fdone", fetch_done, 1);
    chk("c_c5_ddone", data_done, 0);
    chk("c_c5_frd", fetch_rdata, 32'h1234_5678);
    chk("c_c5_drd", data_rdata, 32'hCAFE_F00D);
    fetch_req = 0;
    cyc(); settle();
    chk("c_c6_dones", {fetch_done, data_done}, 0);

    // Misaligned fetch
    fetch_req = 1; fetch_addr = 32'hBFC0_0002; settle();
    chk("m_c0_stall", stall, 1);
    cyc(); settle();
    chk("m_c1_done", fetch_done, 1);
    chk("m_c1_aerr", addr_err, 1);
    chk("m_c1_frd", fetch_rdata, 0);
    chk("m_c1_read", read, 0);
    chk("m_c1_stall", stall, 0);
    fetch_req = 0;
    cyc(); settle();
    chk("m_c2_aerr", addr_err, 0);
    chk("m_c2_done", fetch_done, 0);

    // Reset during a stalled load
    data_req = 1; data_we = 0; data_addr = 32'h0000_3000; waitrequest = 1;
    cyc(); settle();
    chk("r_c1_read", read, 1);
    cyc();
    #1 rst = 1'b0; data_req = 0;
    #1;
    chk("r_read", read, 0);
    chk("r_write", write, 0);
    chk("r_addr", address, 0);
    chk("r_stall", stall, 0);
    chk("r_done", {fetch_done, data_done}, 0);
    cyc();
    rst = 1'b1; waitrequest = 0;
    cyc(); settle();
    chk("r_post_done", {fetch_done, data_done}, 0);
    fetch_req = 1; fetch_addr = 32'h0000_0040; readdata = 32'h0BAD_F00D;
    cyc(); settle();
    chk("r_f_read", read, 1);
    chk("r_f_addr", address, 32'h0000_0040);
    cyc(); settle();
    chk("r_f_done", fetch_done, 1);
    chk("r_f_rdata", fetch_rdata, 32'h0BAD_F00D);
    fetch_req = 0;
    cyc(); settle();
    chk("bt_default", bus_timeout, 0);

`ifdef MEM_TIMEOUT_EN
    // Watchdog: waitrequest stuck high
    begin
      int n;
      n = 0;
      fetch_req = 1; fetch_addr = 32'h0000_0080; waitrequest = 1; readdata = 32'h5555_5555;
      cyc();
      while (fetch_done !== 1'b1 && n < 400) begin
        cyc(); n++;
      end
      settle();
      chk("to_latency", n, 255);
      chk("to_done", fetch_done, 1);
      chk("to_rdata", fetch_rdata, 0);
      chk("to_flag", bus_timeout, 1);
      chk("to_read", read, 0);
      fetch_req = 0;
      cyc(); cyc(); settle();
      chk("to_sticky", bus_timeout, 1);
      waitrequest = 0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
